// File: rtl/cc_alu_pkg.sv
// Shared constants for the CC_ALU controller: ALU selection codes, FSM encoding and PSR layout.
package cc_alu_pkg;

  localparam logic [3:0] ALU_SEL_BUSA  = 4'b0000;
  localparam logic [3:0] ALU_SEL_ADDCC = 4'b0011;
  localparam logic [3:0] ALU_SEL_ADD   = 4'b1000;
  localparam logic [3:0] ALU_SEL_NOP   = 4'b1111;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_MUL  = 2'b10;
  localparam logic [1:0] ST_RESP = 2'b11;

  localparam int unsigned PSR_W = 4;
  localparam int unsigned PSR_C = 0;
  localparam int unsigned PSR_V = 1;
  localparam int unsigned PSR_Z = 2;
  localparam int unsigned PSR_N = 3;

  typedef logic [PSR_W-1:0] psr_t;

  // The ALU reports its flags active-low; the PSR stores them active-high.
  function automatic psr_t psr_from_flags_n(input logic neg_n, input logic zero_n,
                                            input logic ovf_n, input logic carry_n);
    psr_t p;
    p        = '0;
    p[PSR_N] = ~neg_n;
    p[PSR_Z] = ~zero_n;
    p[PSR_V] = ~ovf_n;
    p[PSR_C] = ~carry_n;
    return p;
  endfunction

endpackage

// File: rtl/cc_alu_psr.sv
// Processor status register {N,Z,V,C}: load-all, load-NZ with V/C cleared, synchronous clear.
module cc_alu_psr
  import cc_alu_pkg::*;
(
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             load_all_i,
  input  logic [PSR_W-1:0] psr_i,
  input  logic             load_nz_i,
  input  logic             n_i,
  input  logic             z_i,
  output logic [PSR_W-1:0] psr_o
);

  logic [PSR_W-1:0] psr_d;
  logic [PSR_W-1:0] psr_q;

  always_comb begin
    psr_d = psr_q;
    if (load_all_i) begin
      psr_d = psr_i;
    end else if (load_nz_i) begin
      psr_d        = '0;
      psr_d[PSR_N] = n_i;
      psr_d[PSR_Z] = z_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      psr_q <= '0;
    end else begin
      psr_q <= psr_d;
    end
  end

  assign psr_o = psr_q;

endmodule

// File: rtl/cc_alu_controller.sv
// Sequencer for the combinational CC_ALU: request/response handshakes, PSR, optional shift-add multiply.
// Define CC_ALU_CONTROLLER_MUL_EN to build the multi-cycle multiply; otherwise multiply requests answer with respErr.
module cc_alu_controller
  import cc_alu_pkg::*;
#(
  parameter int DATAWIDTH_BUS           = 32,
  parameter int DATAWIDTH_ALU_SELECTION = 4
)(
  input  logic                               CC_ALU_CONTROLLER_CLOCK_50,
  input  logic                               CC_ALU_CONTROLLER_RESET_InHigh,
  input  logic                               CC_ALU_CONTROLLER_reqValid_In,
  output logic                               CC_ALU_CONTROLLER_reqReady_Out,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALU_CONTROLLER_reqOp_InBus,
  input  logic                               CC_ALU_CONTROLLER_reqMul_In,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALU_CONTROLLER_reqDataA_InBus,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALU_CONTROLLER_reqDataB_InBus,
  output logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALU_CONTROLLER_aluSelection_OutBus,
  output logic [DATAWIDTH_BUS-1:0]           CC_ALU_CONTROLLER_aluDataA_OutBus,
  output logic [DATAWIDTH_BUS-1:0]           CC_ALU_CONTROLLER_aluDataB_OutBus,
  input  logic [DATAWIDTH_BUS-1:0]           CC_ALU_CONTROLLER_aluData_InBus,
  input  logic                               CC_ALU_CONTROLLER_aluOverflow_InLow,
  input  logic                               CC_ALU_CONTROLLER_aluCarry_InLow,
  input  logic                               CC_ALU_CONTROLLER_aluNegative_InLow,
  input  logic                               CC_ALU_CONTROLLER_aluZero_InLow,
  output logic                               CC_ALU_CONTROLLER_respValid_Out,
  input  logic                               CC_ALU_CONTROLLER_respReady_In,
  output logic [DATAWIDTH_BUS-1:0]           CC_ALU_CONTROLLER_respData_OutBus,
  output logic                               CC_ALU_CONTROLLER_respErr_Out,
  output logic [3:0]                         CC_ALU_CONTROLLER_psr_OutBus
);

  localparam logic [DATAWIDTH_ALU_SELECTION-1:0] SEL_BUSA  = DATAWIDTH_ALU_SELECTION'(ALU_SEL_BUSA);
  localparam logic [DATAWIDTH_ALU_SELECTION-1:0] SEL_ADDCC = DATAWIDTH_ALU_SELECTION'(ALU_SEL_ADDCC);
  localparam logic [DATAWIDTH_ALU_SELECTION-1:0] SEL_ADD   = DATAWIDTH_ALU_SELECTION'(ALU_SEL_ADD);
  localparam logic [DATAWIDTH_ALU_SELECTION-1:0] SEL_NOP   = DATAWIDTH_ALU_SELECTION'(ALU_SEL_NOP);

  logic                               clk;
  logic                               rst;

  logic [1:0]                         state_d,     state_q;
  logic [DATAWIDTH_ALU_SELECTION-1:0] op_d,        op_q;
  logic [DATAWIDTH_BUS-1:0]           a_d,         a_q;
  logic [DATAWIDTH_BUS-1:0]           b_d,         b_q;
  logic [DATAWIDTH_BUS-1:0]           resp_data_d, resp_data_q;
  logic                               resp_err_d,  resp_err_q;

  logic [DATAWIDTH_ALU_SELECTION-1:0] alu_sel;
  logic [DATAWIDTH_BUS-1:0]           alu_a;
  logic [DATAWIDTH_BUS-1:0]           alu_b;

  logic                               psr_load_all;
  logic                               psr_load_nz;
  logic                               psr_n;
  logic                               psr_z;
  psr_t                               psr_flags;

`ifdef CC_ALU_CONTROLLER_MUL_EN
  localparam int unsigned CNT_W = (DATAWIDTH_BUS > 1) ? $clog2(DATAWIDTH_BUS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATAWIDTH_BUS - 1);

  logic [DATAWIDTH_BUS-1:0] p_d,   p_q;
  logic [DATAWIDTH_BUS-1:0] m_d,   m_q;
  logic [DATAWIDTH_BUS-1:0] q_d,   q_q;
  logic [CNT_W-1:0]         cnt_d, cnt_q;
`endif

  assign clk = CC_ALU_CONTROLLER_CLOCK_50;
  assign rst = CC_ALU_CONTROLLER_RESET_InHigh;

  assign psr_flags = psr_from_flags_n(CC_ALU_CONTROLLER_aluNegative_InLow,
                                      CC_ALU_CONTROLLER_aluZero_InLow,
                                      CC_ALU_CONTROLLER_aluOverflow_InLow,
                                      CC_ALU_CONTROLLER_aluCarry_InLow);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    alu_sel      = SEL_NOP;
    alu_a        = '0;
    alu_b        = '0;
    psr_load_all = 1'b0;
    psr_load_nz  = 1'b0;
    psr_n        = 1'b0;
    psr_z        = 1'b0;
`ifdef CC_ALU_CONTROLLER_MUL_EN
    p_d          = p_q;
    m_d          = m_q;
    q_d          = q_q;
    cnt_d        = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (CC_ALU_CONTROLLER_reqValid_In) begin
          op_d       = CC_ALU_CONTROLLER_reqOp_InBus;
          a_d        = CC_ALU_CONTROLLER_reqDataA_InBus;
          b_d        = CC_ALU_CONTROLLER_reqDataB_InBus;
          resp_err_d = 1'b0;
          if (CC_ALU_CONTROLLER_reqMul_In) begin
`ifdef CC_ALU_CONTROLLER_MUL_EN
            p_d     = '0;
            m_d     = CC_ALU_CONTROLLER_reqDataA_InBus;
            q_d     = CC_ALU_CONTROLLER_reqDataB_InBus;
            cnt_d   = '0;
            state_d = ST_MUL;
`else
            resp_data_d = '0;
            resp_err_d  = 1'b1;
            state_d     = ST_RESP;
`endif
          end else begin
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        alu_sel      = op_q;
        alu_a        = a_q;
        alu_b        = b_q;
        resp_data_d  = CC_ALU_CONTROLLER_aluData_InBus;
        psr_load_all = (op_q == SEL_ADDCC);
        state_d      = ST_RESP;
      end

`ifdef CC_ALU_CONTROLLER_MUL_EN
      // One shift-add step per cycle; BUSA passes P through when the multiplier bit is 0.
      ST_MUL: begin
        alu_a = p_q;
        if (q_q[0]) begin
          alu_sel = SEL_ADD;
          alu_b   = m_q;
        end else begin
          alu_sel = SEL_BUSA;
        end
        p_d   = CC_ALU_CONTROLLER_aluData_InBus;
        m_d   = m_q << 1;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          resp_data_d = p_d;
          psr_load_nz = 1'b1;
          psr_n       = p_d[DATAWIDTH_BUS-1];
          psr_z       = (p_d == '0);
          state_d     = ST_RESP;
        end
      end
`endif

      ST_RESP: begin
        if (CC_ALU_CONTROLLER_respReady_In) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

`ifdef CC_ALU_CONTROLLER_MUL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q   <= '0;
      m_q   <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      p_q   <= p_d;
      m_q   <= m_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end
`endif

  cc_alu_psr u_psr (
    .clk_i      (clk),
    .clear_i    (rst),
    .load_all_i (psr_load_all),
    .psr_i      (psr_flags),
    .load_nz_i  (psr_load_nz),
    .n_i        (psr_n),
    .z_i        (psr_z),
    .psr_o      (CC_ALU_CONTROLLER_psr_OutBus)
  );

  assign CC_ALU_CONTROLLER_reqReady_Out        = (state_q == ST_IDLE);
  assign CC_ALU_CONTROLLER_respValid_Out       = (state_q == ST_RESP);
  assign CC_ALU_CONTROLLER_respData_OutBus     = resp_data_q;
  assign CC_ALU_CONTROLLER_respErr_Out         = resp_err_q;
  assign CC_ALU_CONTROLLER_aluSelection_OutBus = alu_sel;
  assign CC_ALU_CONTROLLER_aluDataA_OutBus     = alu_a;
  assign CC_ALU_CONTROLLER_aluDataB_OutBus     = alu_b;

endmodule

// File: tb/tb_cc_alu_controller.sv
// Table-driven scoreboard bench for cc_alu_controller with a behavioural CC_ALU attached to its ALU buses.
module tb_cc_alu_controller;
  import cc_alu_pkg::*;

  localparam int W  = 32;
  localparam int SW = 4;
`ifdef CC_ALU_CONTROLLER_MUL_EN
  localparam int unsigned MUL_LAT = W + 1;
`else
  localparam int unsigned MUL_LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_mul;
  logic [SW-1:0] req_op;
  logic [W-1:0]  req_a, req_b;
  logic [SW-1:0] alu_sel;
  logic [W-1:0]  alu_a, alu_b, alu_res;
  logic          alu_ovf, alu_carry;
  logic          resp_valid, resp_ready, resp_err;
  logic [W-1:0]  resp_data;
  logic [3:0]    psr;
  logic [W:0]    sum_ext;

  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  typedef struct {
    logic          mul;
    logic [SW-1:0] op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  data;
    logic          err;
    logic [3:0]    psr;
    int unsigned   lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    logic [3:0]   psr;
    int unsigned  lat;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: 0100 AND, 0101 OR, 0111 XOR, 1101 SUB are bench-chosen codes for plain ops.
  always_comb begin
    sum_ext   = {1'b0, alu_a} + {1'b0, alu_b};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (alu_sel)
      4'b0000: alu_res = alu_a;
      4'b0011, 4'b1000: begin
        alu_res   = sum_ext[W-1:0];
        alu_carry = sum_ext[W];
        alu_ovf   = (alu_a[W-1] == alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
      end
      4'b0100: alu_res = alu_a & alu_b;
      4'b0101: alu_res = alu_a | alu_b;
      4'b0111: alu_res = alu_a ^ alu_b;
      4'b1101: begin
        alu_res   = alu_a - alu_b;
        alu_carry = (alu_a < alu_b);
        alu_ovf   = 1'b1;
      end
      default: alu_res = '0;
    endcase
  end

  cc_alu_controller #(
    .DATAWIDTH_BUS           (W),
    .DATAWIDTH_ALU_SELECTION (SW)
  ) dut (
    .CC_ALU_CONTROLLER_CLOCK_50            (clk),
    .CC_ALU_CONTROLLER_RESET_InHigh        (rst),
    .CC_ALU_CONTROLLER_reqValid_In         (req_valid),
    .CC_ALU_CONTROLLER_reqReady_Out        (req_ready),
    .CC_ALU_CONTROLLER_reqOp_InBus         (req_op),
    .CC_ALU_CONTROLLER_reqMul_In           (req_mul),
    .CC_ALU_CONTROLLER_reqDataA_InBus      (req_a),
    .CC_ALU_CONTROLLER_reqDataB_InBus      (req_b),
    .CC_ALU_CONTROLLER_aluSelection_OutBus (alu_sel),
    .CC_ALU_CONTROLLER_aluDataA_OutBus     (alu_a),
    .CC_ALU_CONTROLLER_aluDataB_OutBus     (alu_b),
    .CC_ALU_CONTROLLER_aluData_InBus       (alu_res),
    .CC_ALU_CONTROLLER_aluOverflow_InLow   (~alu_ovf),
    .CC_ALU_CONTROLLER_aluCarry_InLow      (~alu_carry),
    .CC_ALU_CONTROLLER_aluNegative_InLow   (~alu_res[W-1]),
    .CC_ALU_CONTROLLER_aluZero_InLow       (~(alu_res == '0)),
    .CC_ALU_CONTROLLER_respValid_Out       (resp_valid),
    .CC_ALU_CONTROLLER_respReady_In        (resp_ready),
    .CC_ALU_CONTROLLER_respData_OutBus     (resp_data),
    .CC_ALU_CONTROLLER_respErr_Out         (resp_err),
    .CC_ALU_CONTROLLER_psr_OutBus          (psr)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic mul, input logic [SW-1:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] data, input logic err,
                              input logic [3:0] p, input int unsigned lat);
    vec_t v;
    v.mul = mul; v.op = op; v.a = a; v.b = b;
    v.data = data; v.err = err; v.psr = p; v.lat = lat;
    return v;
  endfunction

  task automatic drive_req(input vec_t v);
    @(negedge clk);
    req_valid = 1'b1;
    req_mul   = v.mul;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
  endtask

  // Waits for acceptance, records the expected response, and checks the EXEC-cycle ALU drive.
  task automatic accept_req(input vec_t v);
    exp_t e;
    int unsigned n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before_accept", W'(req_ready), W'(1));
    @(posedge clk);
    e.data = v.data; e.err = v.err; e.psr = v.psr; e.lat = v.lat;
    sb.push_back(e);
    @(negedge clk);
    acc_cyc   = cyc;
    req_valid = 1'b0;
    if (!v.mul) begin
      chk("exec_alu_sel", W'(alu_sel), W'(v.op));
      chk("exec_alu_a", alu_a, v.a);
      chk("exec_alu_b", alu_b, v.b);
    end
  endtask

  task automatic wait_resp(output int unsigned lat);
    while (!resp_valid && (cyc - acc_cyc) < 100) @(negedge clk);
    lat = cyc - acc_cyc + 1;
  endtask

  task automatic finish_resp(input int unsigned lat);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got a response, expected none");
    end else begin
      e = sb.pop_front();
      chk("resp_latency", W'(lat), W'(e.lat));
      chk("resp_data", resp_data, e.data);
      chk("resp_err", W'(resp_err), W'(e.err));
      chk("psr", W'(psr), W'(e.psr));
      chk("req_ready_in_resp", W'(req_ready), W'(0));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_after_hs", W'(resp_valid), W'(0));
    chk("req_ready_after_hs", W'(req_ready), W'(1));
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned lat;
    drive_req(v);
    accept_req(v);
    wait_resp(lat);
    finish_resp(lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat;
    int unsigned stray;
    vec_t v;

    vecs[0]  = mk(1'b0, 4'b0011, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 4'b1010, 2);
    vecs[1]  = mk(1'b0, 4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 4'b0101, 2);
    vecs[2]  = mk(1'b0, 4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 4'b0101, 2);
    vecs[3]  = mk(1'b0, 4'b1000, 32'd5,         32'd7,         32'd12,        1'b0, 4'b0101, 2);
    vecs[4]  = mk(1'b0, 4'b0101, 32'h0F,        32'hF0,        32'hFF,        1'b0, 4'b0101, 2);
    vecs[5]  = mk(1'b0, 4'b0111, 32'hFF,        32'h0F,        32'hF0,        1'b0, 4'b0101, 2);
    vecs[6]  = mk(1'b0, 4'b1101, 32'd1,         32'd2,         32'hFFFF_FFFF, 1'b0, 4'b0101, 2);
`ifdef CC_ALU_CONTROLLER_MUL_EN
    vecs[7]  = mk(1'b1, 4'b0011, 32'd6,         32'd7,         32'd42,        1'b0, 4'b0000, MUL_LAT);
    vecs[8]  = mk(1'b1, 4'b0000, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b0, 4'b1000, MUL_LAT);
    vecs[10] = mk(1'b1, 4'b0011, 32'd0,         32'h12345,     32'd0,         1'b0, 4'b0100, MUL_LAT);
`else
    vecs[7]  = mk(1'b1, 4'b0011, 32'd6,         32'd7,         32'd0,         1'b1, 4'b0101, MUL_LAT);
    vecs[8]  = mk(1'b1, 4'b0000, 32'hFFFF_FFFF, 32'd2,         32'd0,         1'b1, 4'b0101, MUL_LAT);
    vecs[10] = mk(1'b1, 4'b0011, 32'd0,         32'h12345,     32'd0,         1'b1, 4'b0000, MUL_LAT);
`endif
    vecs[9]  = mk(1'b0, 4'b0011, 32'd1,         32'd1,         32'd2,         1'b0, 4'b0000, 2);
    vecs[11] = mk(1'b0, 4'b0011, 32'h8000_0000, 32'h8000_0000, 32'd0,         1'b0, 4'b0111, 2);

    rst = 1'b1; req_valid = 1'b0; req_mul = 1'b0; req_op = '0;
    req_a = '0; req_b = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", W'(req_ready), W'(1));
    chk("rst_resp_valid", W'(resp_valid), W'(0));
    chk("rst_resp_data", resp_data, '0);
    chk("rst_resp_err", W'(resp_err), W'(0));
    chk("rst_psr", W'(psr), W'(0));
    chk("rst_alu_sel", W'(alu_sel), W'(4'b1111));
    chk("rst_alu_a", alu_a, '0);
    chk("rst_alu_b", alu_b, '0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Backpressure: response held for 5 cycles while a second request waits.
    v = mk(1'b0, 4'b0011, 32'd3, 32'd4, 32'd7, 1'b0, 4'b0000, 2);
    drive_req(v);
    accept_req(v);
    wait_resp(lat);
    req_valid = 1'b1; req_mul = 1'b0; req_op = 4'b1000; req_a = 32'd10; req_b = 32'd20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", W'(resp_valid), W'(1));
      chk("bp_resp_data", resp_data, 32'd7);
      chk("bp_psr", W'(psr), W'(0));
      chk("bp_req_ready", W'(req_ready), W'(0));
    end
    finish_resp(lat);
    v = mk(1'b0, 4'b1000, 32'd10, 32'd20, 32'd30, 1'b0, 4'b0000, 2);
    accept_req(v);
    wait_resp(lat);
    finish_resp(lat);

    // Reset mid-transaction: PSR set beforehand so its clearing is visible.
    run_vec(mk(1'b0, 4'b0011, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 4'b1010, 2));
`ifdef CC_ALU_CONTROLLER_MUL_EN
    v = mk(1'b1, 4'b0000, 32'd6, 32'd7, 32'd42, 1'b0, 4'b0000, MUL_LAT);
    drive_req(v);
    accept_req(v);
    repeat (9) @(negedge clk);
`else
    v = mk(1'b0, 4'b1000, 32'd1, 32'd2, 32'd3, 1'b0, 4'b1010, 2);
    drive_req(v);
    accept_req(v);
    wait_resp(lat);
    repeat (2) @(negedge clk);
`endif
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    chk("midrst_req_ready", W'(req_ready), W'(1));
    chk("midrst_resp_valid", W'(resp_valid), W'(0));
    chk("midrst_psr", W'(psr), W'(0));
    chk("midrst_alu_sel", W'(alu_sel), W'(4'b1111));
    chk("midrst_alu_a", alu_a, '0);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) stray++;
    end
    chk("midrst_no_response", W'(stray), W'(0));

    run_vec(mk(1'b0, 4'b1000, 32'd2, 32'd3, 32'd5, 1'b0, 4'b0000, 2));
    chk("scoreboard_drained", W'(sb.size()), W'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
